// File: rtl/aidc_lite_block_assemble_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aidc_lite_pkg
// Description : Shared widths, types and helpers for the block assembler.
// Revision    : 1.0 - initial release
// ============================================================================
package aidc_lite_pkg;

    localparam int WORD_W     = 64;
    localparam int NUM_WORDS  = 8;
    localparam int BLK_W      = WORD_W * NUM_WORDS;
    localparam int ADDR_W     = 3;
    localparam int c_NUM_BUFS = 3;

    typedef logic [3:0] blk_len_t;
    typedef logic [1:0] buf_id_t;

    typedef struct packed {
        logic [NUM_WORDS-1:0][WORD_W-1:0] words;
        logic [BLK_W-1:0]                 raw;
        logic                             comp;
        blk_len_t                         len;
        logic                             raw_ok;
    } blk_slot_t;

    function automatic blk_len_t len_from_max(input logic [ADDR_W-1:0] max_addr);
        return blk_len_t'({1'b0, max_addr}) + blk_len_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aidc_lite_block_assemble_if.sv
`default_nettype none
// ============================================================================
// Module      : aidc_lite_block_assemble_if
// Description : Word-write / raw-capture input and block valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
interface aidc_lite_block_assemble_if;
    import aidc_lite_pkg::*;

    logic                     wr_valid_i;
    logic [ADDR_W-1:0]        wr_addr_i;
    logic [WORD_W-1:0]        wr_data_i;
    logic                     done_i;
    logic                     fail_i;
    logic                     raw_valid_i;
    logic [BLK_W-1:0]         raw_data_i;
    logic                     blk_valid_o;
    logic                     blk_ready_i;
    logic [BLK_W-1:0]         blk_data_o;
    logic                     blk_comp_o;
    blk_len_t                 blk_len_o;
    logic                     ovf_o;

    modport master (
        output wr_valid_i, wr_addr_i, wr_data_i, done_i, fail_i,
               raw_valid_i, raw_data_i, blk_ready_i,
        input  blk_valid_o, blk_data_o, blk_comp_o, blk_len_o, ovf_o
    );

    modport slave (
        input  wr_valid_i, wr_addr_i, wr_data_i, done_i, fail_i,
               raw_valid_i, raw_data_i, blk_ready_i,
        output blk_valid_o, blk_data_o, blk_comp_o, blk_len_o, ovf_o
    );

endinterface
`default_nettype wire

// File: rtl/aidc_lite_block_assemble_blk_slot.sv
`default_nettype none
// ============================================================================
// Module      : aidc_lite_blk_slot
// Description : One block buffer: eight code words plus the raw block.
// Revision    : 1.0 - initial release
// ============================================================================
module aidc_lite_blk_slot
    import aidc_lite_pkg::*;
(
    input  wire logic                             clk,
    input  wire logic                             rst,
    input  wire logic                             i_clear,
    input  wire logic                             i_wr_en,
    input  wire logic [ADDR_W-1:0]                i_wr_addr,
    input  wire logic [WORD_W-1:0]                i_wr_data,
    input  wire logic                             i_raw_en,
    input  wire logic [BLK_W-1:0]                 i_raw_data,
    output logic      [NUM_WORDS-1:0][WORD_W-1:0] o_words,
    output logic      [BLK_W-1:0]                 o_raw,
    output logic                                  o_raw_ok,
    output logic                                  o_any_wr,
    output logic      [ADDR_W-1:0]                o_max_addr
);

    logic [NUM_WORDS-1:0][WORD_W-1:0] r_words;
    logic [BLK_W-1:0]                 r_raw;
    logic                             r_raw_ok;
    logic                             r_any_wr;
    logic [ADDR_W-1:0]                r_max_addr;

    // A write or capture in the clearing cycle belongs to the new block, so it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_words    <= '0;
            r_raw      <= '0;
            r_raw_ok   <= 1'b0;
            r_any_wr   <= 1'b0;
            r_max_addr <= '0;
        end else begin
            if (i_clear) begin
                r_words    <= '0;
                r_raw_ok   <= 1'b0;
                r_any_wr   <= 1'b0;
                r_max_addr <= '0;
            end
            if (i_wr_en) begin
                r_words[i_wr_addr] <= i_wr_data;
                r_any_wr           <= 1'b1;
                if (i_clear || (i_wr_addr > r_max_addr)) begin
                    r_max_addr <= i_wr_addr;
                end
            end
            if (i_raw_en) begin
                r_raw    <= i_raw_data;
                r_raw_ok <= 1'b1;
            end
        end
    end

    assign o_words    = r_words;
    assign o_raw      = r_raw;
    assign o_raw_ok   = r_raw_ok;
    assign o_any_wr   = r_any_wr;
    assign o_max_addr = r_max_addr;

endmodule
`default_nettype wire

// File: rtl/aidc_lite_block_assemble.sv
`default_nettype none
// ============================================================================
// Module      : aidc_lite_block_assemble
// Description : Assembles code words into 512-bit blocks, two-deep output queue.
// Revision    : 1.0 - initial release
// ============================================================================
module aidc_lite_block_assemble
    import aidc_lite_pkg::*;
(
    input  wire logic                  clk,
    input  wire logic                  rst,
    aidc_lite_block_assemble_if.slave  blk_if
);

    // Three physical buffers: two queue entries plus the one being filled.
    // The fill buffer is never referenced by the queue, so a drop leaves it
    // in place and a same-cycle pop simply hands the freed buffer back.
    logic [NUM_WORDS-1:0][WORD_W-1:0] w_words    [c_NUM_BUFS];
    logic [BLK_W-1:0]                 w_raw      [c_NUM_BUFS];
    logic                             w_raw_ok   [c_NUM_BUFS];
    logic                             w_any_wr   [c_NUM_BUFS];
    logic [ADDR_W-1:0]                w_max_addr [c_NUM_BUFS];

    logic                r_done_q;
    logic                r_armed;
    logic                r_in_blk;
    buf_id_t             r_fill_id;
    buf_id_t [1:0]       r_q_id;
    logic    [1:0]       r_vld;
    logic    [1:0]       r_q_comp;
    blk_len_t [1:0]      r_q_len;
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic                r_ovf;

    logic                w_start;
    logic                w_cmpl;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic                w_fill_any;
    logic [ADDR_W-1:0]   w_fill_max;
    logic [ADDR_W-1:0]   w_max_incl;
    blk_len_t            w_cmp_len;
    logic    [1:0]       w_vld_nxt;
    buf_id_t [1:0]       w_q_id_nxt;
    logic [c_NUM_BUFS-1:0] w_used;
    buf_id_t             w_fill_nxt;
    buf_id_t             w_rd_id;
    blk_slot_t           w_rd_slot;

    assign w_start = r_armed & r_done_q & ~blk_if.done_i;
    assign w_cmpl  = r_in_blk & ~r_done_q & blk_if.done_i;
    assign w_pop   = blk_if.blk_valid_o & blk_if.blk_ready_i;
    assign w_push  = w_cmpl & (~(&r_vld) | w_pop);
    assign w_drop  = w_cmpl & (&r_vld) & ~w_pop;

    generate
        for (genvar g = 0; g < c_NUM_BUFS; g++) begin : g_slot
            logic w_sel;
            assign w_sel = (r_fill_id == buf_id_t'(g));

            aidc_lite_blk_slot u_slot (
                .clk        (clk),
                .rst        (rst),
                .i_clear    (w_start & w_sel),
                .i_wr_en    (blk_if.wr_valid_i & w_sel),
                .i_wr_addr  (blk_if.wr_addr_i),
                .i_wr_data  (blk_if.wr_data_i),
                .i_raw_en   (blk_if.raw_valid_i & w_sel),
                .i_raw_data (blk_if.raw_data_i),
                .o_words    (w_words[g]),
                .o_raw      (w_raw[g]),
                .o_raw_ok   (w_raw_ok[g]),
                .o_any_wr   (w_any_wr[g]),
                .o_max_addr (w_max_addr[g])
            );
        end
    endgenerate

    always_comb begin
        w_fill_any = w_any_wr[0];
        w_fill_max = w_max_addr[0];
        case (r_fill_id)
            2'd1: begin
                w_fill_any = w_any_wr[1];
                w_fill_max = w_max_addr[1];
            end
            2'd2: begin
                w_fill_any = w_any_wr[2];
                w_fill_max = w_max_addr[2];
            end
            default: ;
        endcase
    end

    // Length must include a write landing in the completion cycle itself.
    always_comb begin
        w_max_incl = w_fill_max;
        if (blk_if.wr_valid_i && (blk_if.wr_addr_i > w_fill_max)) begin
            w_max_incl = blk_if.wr_addr_i;
        end
        w_cmp_len = (w_fill_any | blk_if.wr_valid_i) ? len_from_max(w_max_incl)
                                                     : blk_len_t'(1);
    end

    always_comb begin
        w_vld_nxt  = r_vld;
        w_q_id_nxt = r_q_id;
        if (w_pop) begin
            w_vld_nxt[r_rd_ptr] = 1'b0;
        end
        if (w_push) begin
            w_vld_nxt[r_wr_ptr]  = 1'b1;
            w_q_id_nxt[r_wr_ptr] = r_fill_id;
        end
        w_used = '0;
        for (int b = 0; b < c_NUM_BUFS; b++) begin
            w_used[b] = (w_vld_nxt[0] && (w_q_id_nxt[0] == buf_id_t'(b))) ||
                        (w_vld_nxt[1] && (w_q_id_nxt[1] == buf_id_t'(b)));
        end
        w_fill_nxt = r_fill_id;
        if (w_push) begin
            if (!w_used[0]) begin
                w_fill_nxt = 2'd0;
            end else if (!w_used[1]) begin
                w_fill_nxt = 2'd1;
            end else begin
                w_fill_nxt = 2'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_q  <= 1'b1;
            r_armed   <= 1'b0;
            r_in_blk  <= 1'b0;
            r_fill_id <= 2'd0;
            r_q_id    <= {2'd2, 2'd1};
            r_vld     <= 2'b00;
            r_q_comp  <= 2'b00;
            r_q_len   <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_done_q <= blk_if.done_i;
            // A done_i already low out of reset must not count as a start.
            r_armed  <= r_armed | blk_if.done_i;
            if (w_start) begin
                r_in_blk <= 1'b1;
            end else if (w_cmpl) begin
                r_in_blk <= 1'b0;
            end
            r_fill_id <= w_fill_nxt;
            r_q_id    <= w_q_id_nxt;
            r_vld     <= w_vld_nxt;
            if (w_push) begin
                r_q_comp[r_wr_ptr] <= ~blk_if.fail_i;
                r_q_len[r_wr_ptr]  <= blk_if.fail_i ? blk_len_t'(NUM_WORDS) : w_cmp_len;
            end
            r_wr_ptr <= r_wr_ptr ^ w_push;
            r_rd_ptr <= r_rd_ptr ^ w_pop;
            r_ovf    <= r_ovf | w_drop;
        end
    end

    assign w_rd_id = r_q_id[r_rd_ptr];

    always_comb begin
        w_rd_slot.words  = w_words[0];
        w_rd_slot.raw    = w_raw[0];
        w_rd_slot.raw_ok = w_raw_ok[0];
        case (w_rd_id)
            2'd1: begin
                w_rd_slot.words  = w_words[1];
                w_rd_slot.raw    = w_raw[1];
                w_rd_slot.raw_ok = w_raw_ok[1];
            end
            2'd2: begin
                w_rd_slot.words  = w_words[2];
                w_rd_slot.raw    = w_raw[2];
                w_rd_slot.raw_ok = w_raw_ok[2];
            end
            default: ;
        endcase
        w_rd_slot.comp = r_q_comp[r_rd_ptr];
        w_rd_slot.len  = r_q_len[r_rd_ptr];
    end

    assign blk_if.blk_valid_o = |r_vld;
    assign blk_if.blk_comp_o  = w_rd_slot.comp;
    assign blk_if.blk_len_o   = w_rd_slot.len;
    assign blk_if.blk_data_o  = w_rd_slot.comp   ? BLK_W'(w_rd_slot.words) :
                                w_rd_slot.raw_ok ? w_rd_slot.raw : '0;
    assign blk_if.ovf_o       = r_ovf;

endmodule
`default_nettype wire
